axi_lite_slave_regfile: RTL and testbench
=========================================

# axi_lite_slave_regfile

AXI4-Lite slave that terminates the 4-bit-address, 32-bit-data AXI-Lite master port and implements a four-word register file. It sits directly downstream of the AXI-Lite master. It is the register bank through which the host reaches peripheral control (SPI/I2C configuration words). Three read/write registers drive outputs into the fabric; the fourth word reads back a live status input.

## Interface
Parameters
- RESET_VAL, 32'h0000_0000, reset value of REG0..REG2

Ports
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  synchronous, active-low reset
- AWADDR  in  4  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  32  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  4  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  32  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- reg0_o, reg1_o, reg2_o  out  32 each  current REG0..REG2 contents
- status_i  in  32  sampled on reads of 0xC

## Operation
- Word map, decoded by ADDR[3:2]:
  - 0x0 REG0 R/W
  - 0x4 REG1 R/W
  - 0x8 REG2 R/W
  - 0xC STATUS, read-only; writes are ignored and return OKAY.
- Write path: AW and W are accepted independently, in either order or in the same cycle.
  - Flags aw_done/w_done latch the address and data on their handshakes.
  - AWREADY = ARESETn & !aw_done & !BVALID.
  - WREADY = ARESETn & !w_done & !BVALID.
- Write commit: on the first edge where aw_done & w_done & !BVALID:
  - the addressed register is updated;
  - BVALID is set and BRESP is driven;
  - aw_done and w_done are cleared.
- B phase: BVALID holds, with BRESP stable, until the BVALID&BREADY edge, then clears.
- Read path: ARREADY = ARESETn & !RVALID.
  - On the ARVALID&ARREADY edge, RDATA and RRESP are loaded from the addressed word and RVALID is set.
  - RVALID, RDATA and RRESP hold until the RVALID&RREADY edge.
- Read and write channels are fully independent. A read of a register captured on the same edge as a write commit to that register returns the old value.
- Only one outstanding transaction per direction.
- Reset (ARESETn low at an edge, including mid-transaction):
  - REG0..REG2 = RESET_VAL.
  - BVALID = RVALID = 0; BRESP = RRESP = 2'b00; RDATA = 0.
  - aw_done = w_done = 0; latched address/data are discarded.
  - All READY outputs are 0 while ARESETn is low.
- reg*_o reflect register flops directly.

## Timing
- AW and W handshakes on edge N → commit and BVALID=1 after edge N+1. If the handshakes fall on different edges, N is the later one.
- BVALID & BREADY at edge M → BVALID=0 after M. AWREADY/WREADY return high in the same cycle.
- AR handshake at edge N → RVALID=1 with data after edge N.
- A back-to-back read is accepted earliest at the edge after the R handshake.
- reg*_o update after the commit edge.

## Configuration
- AXIL_SLAVE_ADDR_CHECK_EN
  - Defined: an address with ADDR[1:0] != 2'b00 is a misaligned access and returns SLVERR (2'b10).
    - Writes: the commit is suppressed.
    - Reads: RDATA = 32'h0.
    - Handshake timing is unchanged.
  - Undefined: ADDR[1:0] is ignored and every response is OKAY (2'b00).

## Test plan
- Reset value:
  - Stimulus: reset, then read 0x0, 0x4, 0x8 with RESET_VAL=0.
  - Required: RDATA=0, RRESP=OKAY, each RVALID one cycle after its AR handshake.
- Aligned write/read:
  - Stimulus: AW=0x4 and W=32'hDEAD_BEEF in the same cycle.
  - Required: BVALID two edges after the handshake, BRESP=0, reg1_o=DEADBEEF. A subsequent read of 0x4 returns DEADBEEF.
- Out-of-order W/AW with BREADY low:
  - Stimulus: W=32'h1234_5678 first, AW=0x8 three cycles later; BREADY held low 4 cycles.
  - Required: BVALID stays asserted with BRESP stable; AWREADY=WREADY=0 until the B handshake; reg2_o=12345678.
- Status read-only:
  - Stimulus: status_i=32'hA5A5_0001. Write 0xC with 0xFFFF_FFFF, then read 0xC.
  - Required: write response OKAY; read returns A5A50001.
- Concurrent access and reset:
  - Stimulus: write 0x0=0x1 and read 0x0 committed/captured on the same edge; then assert reset while BVALID=1.
  - Required: the read returns the prior value. After reset, BVALID=0 and reg0_o=0.
- Misaligned (macro defined):
  - Stimulus: write 0x5 with 0x77; read 0x2.
  - Required: BRESP=2'b10 with reg1_o unchanged; RRESP=2'b10 with RDATA=0.
  - With the macro undefined: the write lands in REG1 and the read returns REG0 with OKAY.

Source files
------------

// File: rtl/axi_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle (4-bit address, 32-bit data) carrying the five channels
// between a host master and the axi_lite_slave_regfile register bank.
interface axi_lite_slave_regfile_if;
   logic [3:0]  AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [3:0]  ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport slave (
      input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave with three R/W control words and one read-only status word.
// Optional macro AXIL_SLAVE_ADDR_CHECK_EN turns misaligned accesses into SLVERR.
module axi_lite_slave_regfile #(
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   axi_lite_slave_regfile_if.slave        axi,
   output logic [31:0]                    reg0_o,
   output logic [31:0]                    reg1_o,
   output logic [31:0]                    reg2_o,
   input  logic [31:0]                    status_i
);

   logic        aw_done_r;
   logic        w_done_r;
   logic [3:0]  awaddr_r;
   logic [31:0] wdata_r;
   logic        bvalid_r;
   logic [1:0]  bresp_r;
   logic        rvalid_r;
   logic [31:0] rdata_r;
   logic [1:0]  rresp_r;
   logic [31:0] reg0_r;
   logic [31:0] reg1_r;
   logic [31:0] reg2_r;

   logic        awready_s;
   logic        wready_s;
   logic        arready_s;
   logic        aw_hs_s;
   logic        w_hs_s;
   logic        ar_hs_s;
   logic        b_hs_s;
   logic        r_hs_s;
   logic        commit_s;
   logic        wr_err_s;
   logic        rd_err_s;
   logic [31:0] rd_word_s;

   // Ready generation and handshake/commit qualifiers
   always_comb begin
      awready_s = ARESETn & ~aw_done_r & ~bvalid_r;
      wready_s  = ARESETn & ~w_done_r  & ~bvalid_r;
      arready_s = ARESETn & ~rvalid_r;
      aw_hs_s   = axi.AWVALID & awready_s;
      w_hs_s    = axi.WVALID  & wready_s;
      ar_hs_s   = axi.ARVALID & arready_s;
      b_hs_s    = bvalid_r & axi.BREADY;
      r_hs_s    = rvalid_r & axi.RREADY;
      commit_s  = aw_done_r & w_done_r & ~bvalid_r;
   end

`ifdef AXIL_SLAVE_ADDR_CHECK_EN
   // Misalignment detection on the latched write address and live read address
   always_comb begin
      wr_err_s = (awaddr_r[1:0] != 2'b00);
      rd_err_s = (axi.ARADDR[1:0] != 2'b00);
   end
`else
   // Byte-offset bits are don't-care; every access completes OKAY
   always_comb begin
      wr_err_s = 1'b0;
      rd_err_s = 1'b0;
   end

   logic unused_s;
   assign unused_s = ^{awaddr_r[1:0], axi.ARADDR[1:0]};
`endif

   // Read word select; flop values here are pre-commit, so a same-edge read sees old data
   always_comb begin
      rd_word_s = 32'h0000_0000;
      case (axi.ARADDR[3:2])
         2'b00:   rd_word_s = reg0_r;
         2'b01:   rd_word_s = reg1_r;
         2'b10:   rd_word_s = reg2_r;
         2'b11:   rd_word_s = status_i;
         default: rd_word_s = 32'h0000_0000;
      endcase
   end

   // Write address/data capture and B channel
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         awaddr_r  <= 4'h0;
         wdata_r   <= 32'h0000_0000;
         bvalid_r  <= 1'b0;
         bresp_r   <= 2'b00;
      end else begin
         if (aw_hs_s) begin
            aw_done_r <= 1'b1;
            awaddr_r  <= axi.AWADDR;
         end else if (commit_s) begin
            aw_done_r <= 1'b0;
         end
         if (w_hs_s) begin
            w_done_r <= 1'b1;
            wdata_r  <= axi.WDATA;
         end else if (commit_s) begin
            w_done_r <= 1'b0;
         end
         if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_err_s ? 2'b10 : 2'b00;
         end else if (b_hs_s) begin
            bvalid_r <= 1'b0;
         end
      end
   end

   // Register file update on commit; the status word ignores writes
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         reg0_r <= RESET_VAL;
         reg1_r <= RESET_VAL;
         reg2_r <= RESET_VAL;
      end else if (commit_s && !wr_err_s) begin
         case (awaddr_r[3:2])
            2'b00:   reg0_r <= wdata_r;
            2'b01:   reg1_r <= wdata_r;
            2'b10:   reg2_r <= wdata_r;
            default: reg0_r <= reg0_r;
         endcase
      end
   end

   // R channel: load on AR handshake, hold until R handshake
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
         rresp_r  <= 2'b00;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_err_s ? 32'h0000_0000 : rd_word_s;
         rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
      end else if (r_hs_s) begin
         rvalid_r <= 1'b0;
      end
   end

   assign axi.AWREADY = awready_s;
   assign axi.WREADY  = wready_s;
   assign axi.BVALID  = bvalid_r;
   assign axi.BRESP   = bresp_r;
   assign axi.ARREADY = arready_s;
   assign axi.RVALID  = rvalid_r;
   assign axi.RDATA   = rdata_r;
   assign axi.RRESP   = rresp_r;
   assign reg0_o      = reg0_r;
   assign reg1_o      = reg1_r;
   assign reg2_o      = reg2_r;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Self-checking bench for axi_lite_slave_regfile: directed scenarios followed by
// randomized traffic checked against an array-based model of the register map.
module tb_axi_lite_slave_regfile;

`ifdef AXIL_SLAVE_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] reg0, reg1, reg2;
   logic [31:0] status;
   logic [31:0] model [0:2];
   int          n_checks = 0;
   int          n_fail   = 0;

   axi_lite_slave_regfile_if bus ();

   axi_lite_slave_regfile #(.RESET_VAL(32'h0000_0000)) dut (
      .ACLK     (clk),
      .ARESETn  (rst_n),
      .axi      (bus),
      .reg0_o   (reg0),
      .reg1_o   (reg1),
      .reg2_o   (reg2),
      .status_i (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] resp_for(input logic [3:0] a);
      return (CHK && a[1:0] != 2'b00) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      if (resp_for(a) != 2'b00) return 32'h0000_0000;
      if (a[3:2] == 2'b11) return status;
      return model[a[3:2]];
   endfunction

   task automatic check_regs(input string tag);
      chk({tag, " reg0_o"}, reg0, model[0]);
      chk({tag, " reg1_o"}, reg1, model[1]);
      chk({tag, " reg2_o"}, reg2, model[2]);
   endtask

   // lead > 0: W presented lead cycles before AW; lead < 0: AW first
   task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                           input int lead, input int b_hold);
      int  t_aw, t_w, cyc;
      bit  aw_ok, w_ok, aw_fire, w_fire;
      logic [1:0] er;
      t_aw  = (lead > 0) ? lead : 0;
      t_w   = (lead < 0) ? -lead : 0;
      aw_ok = 1'b0;
      w_ok  = 1'b0;
      cyc   = 0;
      er    = resp_for(addr);
      while (!(aw_ok && w_ok) && cyc < 20) begin
         if (!aw_ok && cyc >= t_aw) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
         if (!w_ok && cyc >= t_w) begin bus.WVALID = 1'b1; bus.WDATA = data; end
         aw_fire = bus.AWVALID && bus.AWREADY;
         w_fire  = bus.WVALID && bus.WREADY;
         @(posedge clk); #1;
         if (aw_fire) begin aw_ok = 1'b1; bus.AWVALID = 1'b0; end
         if (w_fire)  begin w_ok  = 1'b1; bus.WVALID  = 1'b0; end
         cyc++;
      end
      chk("wr handshakes complete", {31'd0, aw_ok && w_ok}, 32'd1);
      chk("wr bvalid before commit", {31'd0, bus.BVALID}, 32'd0);
      chk("wr awready after hs", {31'd0, bus.AWREADY}, 32'd0);
      chk("wr wready after hs", {31'd0, bus.WREADY}, 32'd0);
      @(posedge clk); #1;
      if (er == 2'b00 && addr[3:2] != 2'b11) model[addr[3:2]] = data;
      chk("wr bvalid at commit", {31'd0, bus.BVALID}, 32'd1);
      chk("wr bresp", {30'd0, bus.BRESP}, {30'd0, er});
      check_regs("wr commit");
      for (int i = 0; i < b_hold; i++) begin
         @(posedge clk); #1;
         chk("wr bvalid hold", {31'd0, bus.BVALID}, 32'd1);
         chk("wr bresp hold", {30'd0, bus.BRESP}, {30'd0, er});
         chk("wr ready blocked", {30'd0, bus.AWREADY, bus.WREADY}, 32'd0);
      end
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
      chk("wr bvalid cleared", {31'd0, bus.BVALID}, 32'd0);
      chk("wr ready restored", {30'd0, bus.AWREADY, bus.WREADY}, 32'd3);
   endtask

   task automatic do_read(input logic [3:0] addr, input int r_hold);
      logic [31:0] ed;
      logic [1:0]  er;
      ed = exp_read(addr);
      er = resp_for(addr);
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      chk("rd arready idle", {31'd0, bus.ARREADY}, 32'd1);
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      chk("rd rvalid", {31'd0, bus.RVALID}, 32'd1);
      chk("rd rdata", bus.RDATA, ed);
      chk("rd rresp", {30'd0, bus.RRESP}, {30'd0, er});
      for (int i = 0; i < r_hold; i++) begin
         @(posedge clk); #1;
         chk("rd rvalid hold", {31'd0, bus.RVALID}, 32'd1);
         chk("rd rdata hold", bus.RDATA, ed);
         chk("rd arready blocked", {31'd0, bus.ARREADY}, 32'd0);
      end
      bus.RREADY = 1'b1;
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
      chk("rd rvalid cleared", {31'd0, bus.RVALID}, 32'd0);
      chk("rd arready restored", {31'd0, bus.ARREADY}, 32'd1);
   endtask

   initial begin
      logic [31:0] r0;
      rst_n       = 1'b0;
      status      = 32'h0000_0000;
      bus.AWADDR  = 4'h0; bus.AWVALID = 1'b0;
      bus.WDATA   = 32'h0; bus.WVALID = 1'b0;
      bus.BREADY  = 1'b0;
      bus.ARADDR  = 4'h0; bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;
      for (int i = 0; i < 3; i++) model[i] = 32'h0000_0000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst readies low", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
      chk("rst bvalid", {31'd0, bus.BVALID}, 32'd0);
      chk("rst rvalid", {31'd0, bus.RVALID}, 32'd0);
      chk("rst rdata", bus.RDATA, 32'd0);
      check_regs("rst");
      rst_n = 1'b1;
      #1;
      chk("post-rst readies", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);
      do_read(4'h0, 0);
      do_read(4'h4, 0);
      do_read(4'h8, 0);

      // Aligned write/read with AW and W together
      do_write(4'h4, 32'hDEAD_BEEF, 0, 0);
      do_read(4'h4, 1);

      // W three cycles ahead of AW, BREADY held low for four cycles
      do_write(4'h8, 32'h1234_5678, 3, 4);
      do_read(4'h8, 0);

      // Status word is read-only
      status = 32'hA5A5_0001;
      do_write(4'hC, 32'hFFFF_FFFF, 0, 0);
      do_read(4'hC, 0);

      // Misaligned accesses
      do_write(4'h5, 32'h0000_0077, 0, 0);
      do_read(4'h2, 0);

      // Same-edge write commit and read capture, then reset with BVALID pending
      r0 = $urandom | 32'h0000_0100;
      do_write(4'h0, r0, -2, 0);
      bus.AWADDR = 4'h0; bus.AWVALID = 1'b1;
      bus.WDATA  = 32'h0000_0001; bus.WVALID = 1'b1;
      @(posedge clk); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      bus.ARADDR = 4'h0; bus.ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.ARVALID = 1'b0;
      chk("same-edge rvalid", {31'd0, bus.RVALID}, 32'd1);
      chk("same-edge old rdata", bus.RDATA, r0);
      chk("same-edge bvalid", {31'd0, bus.BVALID}, 32'd1);
      chk("same-edge reg0_o new", reg0, 32'h0000_0001);
      rst_n = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) model[i] = 32'h0000_0000;
      chk("mid-rst bvalid", {31'd0, bus.BVALID}, 32'd0);
      chk("mid-rst rvalid", {31'd0, bus.RVALID}, 32'd0);
      chk("mid-rst bresp", {30'd0, bus.BRESP}, 32'd0);
      chk("mid-rst readies low", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
      check_regs("mid-rst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_read(4'h0, 0);

      // Randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         status = $urandom;
         if ($urandom_range(0, 1) == 0)
            do_write(4'($urandom_range(0, 15)), $urandom,
                     int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
         else
            do_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      check_regs("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
